// File: rtl/rr_switch_arbiter_pkg.sv
// Shared definitions for the round-robin switch arbiter: FSM encodings and flit layout helpers.
package rr_switch_arbiter_pkg;

    typedef logic [0:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 1'b0;
    localparam arb_state_t ST_SEND = 1'b1;

    function automatic int flit_width(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

    function automatic int tail_bit(input int data_size, input int addr_size);
        return data_size + addr_size;
    endfunction

endpackage

// File: rtl/rr_switch_arbiter_picker.sv
// Combinational round-robin picker: chooses the first requester after last_ptr, with wrap.
module rr_picker #(
    parameter int N  = 5,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] last_ptr,
    output logic [N-1:0]  grant_next,
    output logic [PW-1:0] grant_idx,
    output logic          valid
);

    logic [PW:0]  shift_s;
    logic [N-1:0] rot_s;
    logic [N-1:0] rot_oh_s;
    logic         found_s;

    // Rotate so that bit 0 is the port right after the previous owner.
    assign shift_s = {1'b0, last_ptr} + {{PW{1'b0}}, 1'b1};
    assign rot_s   = N'({req, req} >> shift_s);

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        rot_oh_s = '0;
        found_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            rot_oh_s[k] = rot_s[k] & ~found_s;
            found_s     = found_s | rot_s[k];
        end
    end

    assign grant_next = N'(({rot_oh_s, rot_oh_s} << shift_s) >> N);
    assign valid      = found_s;

    // One-hot grant to binary index.
    always_comb begin
        grant_idx = '0;
        for (int j = 0; j < N; j++) begin
            grant_idx = grant_idx | (grant_next[j] ? PW'(j) : '0);
        end
    end

endmodule

// File: rtl/rr_switch_arbiter.sv
// Round-robin output-link arbiter: one packet at a time from PORTS_NUM+1 input FIFOs to a downstream buffer.
module rr_switch_arbiter
    import rr_switch_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 4,
    parameter int ADDR_SIZE = 1,
    parameter int PORTS_NUM = 4,
    parameter int PKT_MAX   = 8
) (
    input  logic                                                 clk,
    input  logic                                                 a_rst,
    input  logic [PORTS_NUM:0]                                   req,
    input  logic [(DATA_SIZE+ADDR_SIZE+1)*(PORTS_NUM+1)-1:0]     data_i,
    input  logic                                                 is_full,
    output logic [PORTS_NUM:0]                                   rd_req,
    output logic                                                 wr_req,
    output logic [DATA_SIZE+ADDR_SIZE:0]                         data_o,
    output logic [PORTS_NUM:0]                                   grant,
    output logic                                                 pkt_err
);

    localparam int NP = PORTS_NUM + 1;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;
    localparam int CW = $clog2(PKT_MAX + 1);
    localparam int FW = flit_width(DATA_SIZE, ADDR_SIZE);
    localparam int TB = tail_bit(DATA_SIZE, ADDR_SIZE);

    localparam logic [CW-1:0] CNT_LAST = CW'(PKT_MAX - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(PORTS_NUM);

    arb_state_t     state_r, state_n;
    logic [NP-1:0]  grant_r, grant_n;
    logic [PW-1:0]  gidx_r, gidx_n;
    logic [PW-1:0]  last_ptr_r, last_ptr_n;
    logic [CW-1:0]  flit_cnt_r, flit_cnt_n;
    logic           pkt_err_r, pkt_err_n;

    logic [NP-1:0]  pick_grant_s;
    logic [PW-1:0]  pick_idx_s;
    logic           pick_valid_s;
    logic [FW-1:0]  head_s;
    logic           req_g_s;
    logic           sel_s;
    logic           send_s;
    logic           xfer_s;
    logic           tail_s;
    logic           release_s;

    rr_picker #(
        .N  (NP),
        .PW (PW)
    ) u_picker (
        .req        (req),
        .last_ptr   (last_ptr_r),
        .grant_next (pick_grant_s),
        .grant_idx  (pick_idx_s),
        .valid      (pick_valid_s)
    );

    // Select the granted port's head flit and request line.
    always_comb begin
        head_s  = '0;
        req_g_s = 1'b0;
        sel_s   = 1'b0;
        for (int i = 0; i < NP; i++) begin
            sel_s   = (gidx_r == PW'(i));
            head_s  = head_s | (data_i[i*FW +: FW] & {FW{sel_s}});
            req_g_s = req_g_s | (req[i] & sel_s);
        end
    end

    assign send_s    = (state_r == ST_SEND);
    assign xfer_s    = send_s & req_g_s & ~is_full;
    assign tail_s    = head_s[TB];
    assign release_s = xfer_s & (tail_s | (flit_cnt_r == CNT_LAST));

    assign rd_req  = grant_r & {NP{xfer_s}};
    assign wr_req  = xfer_s;
    assign data_o  = send_s ? head_s : '0;
    assign grant   = grant_r;
    assign pkt_err = pkt_err_r;

    // Next-state logic: pick an owner in IDLE, count flits and release in SEND.
    always_comb begin
        state_n    = state_r;
        grant_n    = grant_r;
        gidx_n     = gidx_r;
        last_ptr_n = last_ptr_r;
        flit_cnt_n = flit_cnt_r;
        pkt_err_n  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_n    = ST_SEND;
                    grant_n    = pick_grant_s;
                    gidx_n     = pick_idx_s;
                    flit_cnt_n = '0;
                end else begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                end
            end
            ST_SEND: begin
                if (release_s) begin
                    state_n    = ST_IDLE;
                    grant_n    = '0;
                    last_ptr_n = gidx_r;
                    flit_cnt_n = '0;
                    pkt_err_n  = ~tail_s;
                end else if (xfer_s) begin
                    flit_cnt_n = flit_cnt_r + CW'(1);
                end else begin
                    flit_cnt_n = flit_cnt_r;
                end
            end
            default: begin
                state_n    = ST_IDLE;
                grant_n    = '0;
                flit_cnt_n = '0;
            end
        endcase
    end

    // State registers; reset leaves last_ptr at the top port so port 0 wins first.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_r    <= ST_IDLE;
            grant_r    <= '0;
            gidx_r     <= '0;
            last_ptr_r <= PTR_RST;
            flit_cnt_r <= '0;
            pkt_err_r  <= 1'b0;
        end else begin
            state_r    <= state_n;
            grant_r    <= grant_n;
            gidx_r     <= gidx_n;
            last_ptr_r <= last_ptr_n;
            flit_cnt_r <= flit_cnt_n;
            pkt_err_r  <= pkt_err_n;
        end
    end

endmodule
